// File: rtl/persiana_pkg.sv
// persiana_pkg
// Shared encodings for the blind-motor command arbiter:
//   - target / position codes (same code space as the light-sensor input)
//   - requester grant codes
//   - FSM state codes
//   - man_to_pos(): one-hot manual request -> target code (POS_NONE if not one-hot)
// The target/position codes are numerically ordered bottom-to-top
// (closed < middle < open), so direction is a plain magnitude compare.
package persiana_pkg;

    typedef logic [1:0] pos_t;
    typedef logic [1:0] grant_t;

    localparam pos_t POS_NONE   = 2'b00;
    localparam pos_t POS_CLOSED = 2'b01;
    localparam pos_t POS_MIDDLE = 2'b10;
    localparam pos_t POS_OPEN   = 2'b11;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_MAN  = 2'b01;
    localparam grant_t GRANT_AUTO = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN_UP = 3'd1;
    localparam logic [2:0] ST_RUN_DN = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    // man_req is {abrir, medio, cerrar}
    function automatic pos_t man_to_pos(input logic [2:0] man_req);
        case (man_req)
            3'b100:  man_to_pos = POS_OPEN;
            3'b010:  man_to_pos = POS_MIDDLE;
            3'b001:  man_to_pos = POS_CLOSED;
            default: man_to_pos = POS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/persiana_tick_cnt.sv
// persiana_tick_cnt
// Saturating up-counter of prescaler ticks with synchronous clear.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous clear (wins over tick)
//   tick   - count enable strobe
//   at_max - high once MAX ticks have been counted; holds there (no wrap)
module persiana_tick_cnt
    import persiana_pkg::*;
#(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic at_max
);

    localparam int         W     = $clog2(MAX) + 1;
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q < MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q >= MAX_V);

endmodule

// File: rtl/persiana_cmd_arbiter.sv
// persiana_cmd_arbiter
// Arbitrates manual and automatic (light sensor) blind-position requests and
// drives the up/down motor commands with dead time on every reversal.
// Optional motion timeout: define PERSIANA_TIMEOUT_EN to enable the FAULT path
// (timeout and multi-limit-sensor faults); otherwise fault is tied 0.
// Ports:
//   clk, reseteo_n       - clock, asynchronous active-low reset
//   tick                 - prescaler strobe for dead time / timeout counters
//   man_req[2:0]         - one-hot manual target {abrir, medio, cerrar}
//   auto_en, sensor[1:0] - automatic requester enable and target
//   s_inf, s_med, s_sup  - limit sensors (closed, middle, open)
//   clear_fault          - leaves FAULT (timeout build only)
//   subir, bajar         - registered motor commands
//   grant[1:0]           - active requester (00 none, 01 manual, 10 auto)
//   target[1:0]          - latched target
//   busy, done, fault    - motion/settling, target-reached pulse, FAULT state
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | motor off, waiting for a request
// RUN_UP  | subir=1, travelling towards a higher target
// RUN_DN  | bajar=1, travelling towards a lower target
// SETTLE  | motor off for DEAD_TICKS ticks before running settle_up_q dir
// FAULT   | motor off, fault=1 until clear_fault (timeout build only)
module persiana_cmd_arbiter
    import persiana_pkg::*;
#(
    parameter int DEAD_TICKS    = 2,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       reseteo_n,
    input  logic       tick,
    input  logic [2:0] man_req,
    input  logic       auto_en,
    input  logic [1:0] sensor,
    input  logic       s_inf,
    input  logic       s_med,
    input  logic       s_sup,
    input  logic       clear_fault,
    output logic       subir,
    output logic       bajar,
    output logic [1:0] grant,
    output logic [1:0] target,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    logic [2:0] state_q, state_d;
    pos_t       pos_q, pos_d;
    pos_t       target_q, target_d;
    grant_t     grant_q, grant_d;
    logic       settle_up_q, settle_up_d;
    logic       subir_q, subir_d;
    logic       bajar_q, bajar_d;
    logic       done_q, done_d;

    logic       running;
    logic       dead_at_max;
    logic       to_at_max;
    logic       clr_fault_in;
    logic [2:0] stop_state;

    // ---------------- request arbitration ----------------
    pos_t   man_pos;
    pos_t   req_pos;
    grant_t req_grant;
    logic   req_valid;

    assign man_pos = man_to_pos(man_req);

    always_comb begin
        req_valid = 1'b0;
        req_pos   = POS_NONE;
        req_grant = GRANT_NONE;
        if (man_pos != POS_NONE) begin
            req_valid = 1'b1;
            req_pos   = man_pos;
            req_grant = GRANT_MAN;
        end else if (auto_en && (sensor != POS_NONE)) begin
            req_valid = 1'b1;
            req_pos   = sensor;
            req_grant = GRANT_AUTO;
        end
    end

    // ---------------- limit sensors ----------------
    logic lim_multi;
    logic tgt_hit;

    assign lim_multi = (s_inf & s_med) | (s_inf & s_sup) | (s_med & s_sup);
    assign tgt_hit   = ((target_q == POS_CLOSED) & s_inf) |
                       ((target_q == POS_MIDDLE) & s_med) |
                       ((target_q == POS_OPEN)   & s_sup);

    // ---------------- direction decisions ----------------
    // From rest: unknown position means only "closed" lies below.
    logic idle_up;
    logic idle_eq;
    assign idle_up = (pos_q == POS_NONE) ? (req_pos != POS_CLOSED) : (req_pos > pos_q);
    assign idle_eq = (pos_q != POS_NONE) && (req_pos == pos_q);

    // While moving, pos_q is the sensor just left behind, so a target equal
    // to it lies behind the motor and needs a reversal.
    logic mv_up;
    always_comb begin
        if (state_q == ST_RUN_UP) begin
            mv_up = (pos_q == POS_NONE) ? (req_pos != POS_CLOSED) : (req_pos > pos_q);
        end else begin
            mv_up = (pos_q == POS_NONE) ? (req_pos != POS_CLOSED) : !(req_pos < pos_q);
        end
    end

    // Manual may override auto mid-motion; auto never overrides manual.
    logic retarget;
    assign retarget = req_valid &&
                      !((grant_q == GRANT_MAN) && (req_grant == GRANT_AUTO)) &&
                      ((req_pos != target_q) || (req_grant != grant_q));

    // ---------------- counters ----------------
    assign running = (state_q == ST_RUN_UP) || (state_q == ST_RUN_DN);

    persiana_tick_cnt #(.MAX(DEAD_TICKS)) u_dead (
        .clk    (clk),
        .rst_n  (reseteo_n),
        .clr    (state_q != ST_SETTLE),
        .tick   (tick),
        .at_max (dead_at_max)
    );

`ifdef PERSIANA_TIMEOUT_EN
    persiana_tick_cnt #(.MAX(TIMEOUT_TICKS)) u_timeout (
        .clk    (clk),
        .rst_n  (reseteo_n),
        .clr    (!running),
        .tick   (tick),
        .at_max (to_at_max)
    );
    assign clr_fault_in = clear_fault;
    assign stop_state   = ST_FAULT;
    assign fault        = (state_q == ST_FAULT);
`else
    localparam int unused_timeout_ticks = TIMEOUT_TICKS;
    logic unused_clear_fault;
    assign unused_clear_fault = clear_fault;
    assign to_at_max          = 1'b0;
    assign clr_fault_in       = 1'b0;
    assign stop_state         = ST_IDLE;
    assign fault              = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        target_d    = target_q;
        grant_d     = grant_q;
        settle_up_d = settle_up_q;
        done_d      = 1'b0;

        // Only an unambiguous single sensor updates the position.
        if (!lim_multi) begin
            if (s_inf) begin
                pos_d = POS_CLOSED;
            end else if (s_med) begin
                pos_d = POS_MIDDLE;
            end else if (s_sup) begin
                pos_d = POS_OPEN;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !lim_multi) begin
                    if (idle_eq) begin
                        // Already there: one done pulse, not repeated while held.
                        if (req_pos != target_q) begin
                            target_d = req_pos;
                            done_d   = 1'b1;
                        end
                    end else begin
                        target_d = req_pos;
                        grant_d  = req_grant;
                        state_d  = idle_up ? ST_RUN_UP : ST_RUN_DN;
                    end
                end
            end
            ST_RUN_UP, ST_RUN_DN: begin
                if (lim_multi || to_at_max) begin
                    state_d = stop_state;
                    grant_d = GRANT_NONE;
                end else if (tgt_hit) begin
                    state_d = ST_IDLE;
                    grant_d = GRANT_NONE;
                    done_d  = 1'b1;
                end else if ((state_q == ST_RUN_UP) && s_sup) begin
                    // Middle overshoot from an unknown start: come back down.
                    if (target_q == POS_MIDDLE) begin
                        state_d     = ST_SETTLE;
                        settle_up_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = GRANT_NONE;
                    end
                end else if ((state_q == ST_RUN_DN) && s_inf) begin
                    state_d = ST_IDLE;
                    grant_d = GRANT_NONE;
                end else if (retarget) begin
                    target_d = req_pos;
                    grant_d  = req_grant;
                    if (mv_up != (state_q == ST_RUN_UP)) begin
                        state_d     = ST_SETTLE;
                        settle_up_d = mv_up;
                    end
                end
            end
            ST_SETTLE: begin
                if (lim_multi) begin
                    state_d = stop_state;
                    grant_d = GRANT_NONE;
                end else if (dead_at_max) begin
                    state_d = settle_up_q ? ST_RUN_UP : ST_RUN_DN;
                end
            end
            ST_FAULT: begin
                if (clr_fault_in) begin
                    state_d = ST_IDLE;
                    pos_d   = POS_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase

        subir_d = (state_d == ST_RUN_UP);
        bajar_d = (state_d == ST_RUN_DN);
    end

    always_ff @(posedge clk or negedge reseteo_n) begin
        if (!reseteo_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= POS_NONE;
            target_q    <= POS_NONE;
            grant_q     <= GRANT_NONE;
            settle_up_q <= 1'b0;
            subir_q     <= 1'b0;
            bajar_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            target_q    <= target_d;
            grant_q     <= grant_d;
            settle_up_q <= settle_up_d;
            subir_q     <= subir_d;
            bajar_q     <= bajar_d;
            done_q      <= done_d;
        end
    end

    assign subir  = subir_q;
    assign bajar  = bajar_q;
    assign grant  = grant_q;
    assign target = target_q;
    assign done   = done_q;
    assign busy   = running || (state_q == ST_SETTLE);

endmodule

// File: tb/tb_persiana_cmd_arbiter.sv
// tb_persiana_cmd_arbiter
// Directed bench with an expected-output scoreboard: each step queues the
// outputs expected after the next clk edge (or immediately, for reset),
// and the queue is drained and compared once the DUT has produced them.
// Works with and without PERSIANA_TIMEOUT_EN.
module tb_persiana_cmd_arbiter;

    logic       clk = 1'b0;
    logic       reseteo_n;
    logic       tick;
    logic [2:0] man_req;
    logic       auto_en;
    logic [1:0] sensor;
    logic       s_inf, s_med, s_sup;
    logic       clear_fault;
    logic       subir, bajar, busy, done, fault;
    logic [1:0] grant, target;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    persiana_cmd_arbiter #(.DEAD_TICKS(2), .TIMEOUT_TICKS(20)) dut (
        .clk         (clk),
        .reseteo_n   (reseteo_n),
        .tick        (tick),
        .man_req     (man_req),
        .auto_en     (auto_en),
        .sensor      (sensor),
        .s_inf       (s_inf),
        .s_med       (s_med),
        .s_sup       (s_sup),
        .clear_fault (clear_fault),
        .subir       (subir),
        .bajar       (bajar),
        .grant       (grant),
        .target      (target),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    function automatic logic [8:0] ev(input logic s, input logic b, input logic [1:0] g,
                                      input logic [1:0] t, input logic bz, input logic d,
                                      input logic f);
        return {s, b, g, t, bz, d, f};
    endfunction

    task automatic expect_out(input string tag, input logic [8:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        logic [8:0] obs;
        logic [8:0] e;
        string      tag;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = {subir, bajar, grant, target, busy, done, fault};
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b (subir bajar grant target busy done fault)",
                       tag, obs, e);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        reseteo_n   = 1'b0;
        tick        = 1'b0;
        man_req     = 3'b000;
        auto_en     = 1'b0;
        sensor      = 2'b00;
        s_inf       = 1'b0;
        s_med       = 1'b0;
        s_sup       = 1'b0;
        clear_fault = 1'b0;

        #3;
        expect_out("reset_async", ev(0,0,2'b00,2'b00,0,0,0));
        drain();
        expect_out("reset_held", ev(0,0,2'b00,2'b00,0,0,0));
        cyc();
        reseteo_n = 1'b1;
        expect_out("idle_after_reset", ev(0,0,2'b00,2'b00,0,0,0));
        cyc();

        // Scenario 1: position closed, open request, reach top
        s_inf = 1'b1;
        expect_out("s1_pos_closed", ev(0,0,2'b00,2'b00,0,0,0));
        cyc();
        s_inf = 1'b0;
        man_req = 3'b100;
        expect_out("s1_run_up", ev(1,0,2'b01,2'b11,1,0,0));
        cyc();
        man_req = 3'b000;
        expect_out("s1_req_vanished", ev(1,0,2'b01,2'b11,1,0,0));
        cyc();
        s_sup = 1'b1;
        expect_out("s1_done", ev(0,0,2'b00,2'b11,0,1,0));
        cyc();
        s_sup = 1'b0;
        expect_out("s1_done_clear", ev(0,0,2'b00,2'b11,0,0,0));
        cyc();

        // Scenario 2: manual beats auto
        auto_en = 1'b1;
        sensor  = 2'b01;
        man_req = 3'b010;
        expect_out("s2_man_wins", ev(0,1,2'b01,2'b10,1,0,0));
        cyc();
        man_req = 3'b000;
        expect_out("s2_auto_ignored", ev(0,1,2'b01,2'b10,1,0,0));
        cyc();
        auto_en = 1'b0;
        sensor  = 2'b00;
        s_med   = 1'b1;
        expect_out("s2_done_mid", ev(0,0,2'b00,2'b10,0,1,0));
        cyc();
        s_med = 1'b0;
        expect_out("s2_idle", ev(0,0,2'b00,2'b10,0,0,0));
        cyc();

        // Auto grant, then Scenario 3: manual reversal through SETTLE
        auto_en = 1'b1;
        sensor  = 2'b11;
        expect_out("auto_run_up", ev(1,0,2'b10,2'b11,1,0,0));
        cyc();
        auto_en = 1'b0;
        sensor  = 2'b00;
        man_req = 3'b001;
        expect_out("s3_settle_enter", ev(0,0,2'b01,2'b01,1,0,0));
        cyc();
        man_req = 3'b000;
        tick = 1'b1;
        expect_out("s3_settle_t1", ev(0,0,2'b01,2'b01,1,0,0));
        cyc();
        tick = 1'b0;
        expect_out("s3_settle_gap", ev(0,0,2'b01,2'b01,1,0,0));
        cyc();
        tick = 1'b1;
        expect_out("s3_settle_t2", ev(0,0,2'b01,2'b01,1,0,0));
        cyc();
        tick = 1'b0;
        expect_out("s3_run_dn", ev(0,1,2'b01,2'b01,1,0,0));
        cyc();
        s_inf = 1'b1;
        expect_out("s3_done_closed", ev(0,0,2'b00,2'b01,0,1,0));
        cyc();
        s_inf = 1'b0;

        // Scenario 5a: two limit sensors during motion
        man_req = 3'b100;
        expect_out("s5_run_up", ev(1,0,2'b01,2'b11,1,0,0));
        cyc();
        man_req = 3'b000;
        s_inf = 1'b1;
        s_med = 1'b1;
`ifdef PERSIANA_TIMEOUT_EN
        expect_out("s5_multi_stop", ev(0,0,2'b00,2'b11,0,0,1));
        cyc();
        s_inf = 1'b0;
        s_med = 1'b0;
        expect_out("s5_fault_held", ev(0,0,2'b00,2'b11,0,0,1));
        cyc();
`else
        expect_out("s5_multi_stop", ev(0,0,2'b00,2'b11,0,0,0));
        cyc();
        s_inf = 1'b0;
        s_med = 1'b0;
        expect_out("s5_idle_held", ev(0,0,2'b00,2'b11,0,0,0));
        cyc();
`endif
        clear_fault = 1'b1;
        expect_out("s5_clear", ev(0,0,2'b00,2'b11,0,0,0));
        cyc();
        clear_fault = 1'b0;

        // Scenario 4: long RUN_DN with no sensor
        s_sup = 1'b1;
        expect_out("s4_pos_open", ev(0,0,2'b00,2'b11,0,0,0));
        cyc();
        s_sup = 1'b0;
        man_req = 3'b001;
        expect_out("s4_run_dn", ev(0,1,2'b01,2'b01,1,0,0));
        cyc();
        man_req = 3'b000;
        for (int i = 0; i < 19; i++) begin
            tick = 1'b1;
            expect_out("s4_running", ev(0,1,2'b01,2'b01,1,0,0));
            cyc();
            tick = 1'b0;
            expect_out("s4_running", ev(0,1,2'b01,2'b01,1,0,0));
            cyc();
        end
        tick = 1'b1;
        expect_out("s4_tick20", ev(0,1,2'b01,2'b01,1,0,0));
        cyc();
        tick = 1'b0;
`ifdef PERSIANA_TIMEOUT_EN
        expect_out("s4_timeout_fault", ev(0,0,2'b00,2'b01,0,0,1));
        cyc();
        expect_out("s4_fault_held", ev(0,0,2'b00,2'b01,0,0,1));
        cyc();
        clear_fault = 1'b1;
        expect_out("s4_clear_fault", ev(0,0,2'b00,2'b01,0,0,0));
        cyc();
        clear_fault = 1'b0;
`else
        expect_out("s4_no_timeout", ev(0,1,2'b01,2'b01,1,0,0));
        cyc();
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            expect_out("s4_no_timeout", ev(0,1,2'b01,2'b01,1,0,0));
            cyc();
            tick = 1'b0;
        end
        clear_fault = 1'b1;
        expect_out("s4_clear_ignored", ev(0,1,2'b01,2'b01,1,0,0));
        cyc();
        clear_fault = 1'b0;
        s_inf = 1'b1;
        expect_out("s4_done_closed", ev(0,0,2'b00,2'b01,0,1,0));
        cyc();
        s_inf = 1'b0;
        expect_out("s4_idle", ev(0,0,2'b00,2'b01,0,0,0));
        cyc();
`endif

        // Request equal to known position: no motion, done pulse
        s_sup = 1'b1;
        expect_out("eq_pos_open", ev(0,0,2'b00,2'b01,0,0,0));
        cyc();
        s_sup = 1'b0;
        man_req = 3'b100;
        expect_out("eq_done", ev(0,0,2'b00,2'b11,0,1,0));
        cyc();
        man_req = 3'b000;
        expect_out("eq_idle", ev(0,0,2'b00,2'b11,0,0,0));
        cyc();

        // Scenario 5b: reset mid-RUN_UP acts without a clk edge
        s_inf = 1'b1;
        expect_out("rst_pos_closed", ev(0,0,2'b00,2'b11,0,0,0));
        cyc();
        s_inf = 1'b0;
        man_req = 3'b100;
        expect_out("rst_run_up", ev(1,0,2'b01,2'b11,1,0,0));
        cyc();
        man_req = 3'b000;
        #3;
        reseteo_n = 1'b0;
        #1;
        expect_out("rst_mid_run", ev(0,0,2'b00,2'b00,0,0,0));
        drain();
        expect_out("rst_mid_held", ev(0,0,2'b00,2'b00,0,0,0));
        cyc();
        reseteo_n = 1'b1;
        expect_out("rst_release", ev(0,0,2'b00,2'b00,0,0,0));
        cyc();

        // Unknown position, middle target, overshoot to top and come back
        man_req = 3'b010;
        expect_out("ov_run_up", ev(1,0,2'b01,2'b10,1,0,0));
        cyc();
        man_req = 3'b000;
        s_sup = 1'b1;
        expect_out("ov_settle", ev(0,0,2'b01,2'b10,1,0,0));
        cyc();
        s_sup = 1'b0;
        tick = 1'b1;
        expect_out("ov_settle_t1", ev(0,0,2'b01,2'b10,1,0,0));
        cyc();
        expect_out("ov_settle_t2", ev(0,0,2'b01,2'b10,1,0,0));
        cyc();
        tick = 1'b0;
        expect_out("ov_run_dn", ev(0,1,2'b01,2'b10,1,0,0));
        cyc();
        s_med = 1'b1;
        expect_out("ov_done", ev(0,0,2'b00,2'b10,0,1,0));
        cyc();
        s_med = 1'b0;
        expect_out("ov_idle", ev(0,0,2'b00,2'b10,0,0,0));
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
